uart_rx_deser: RTL and testbench



---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_baud_cnt.sv | 41 ++++
 rtl/uart_rx_deser.sv | 219 +++++++++++++++++++++
 tb/tb_uart_rx_deser.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive (and matching transmit) path:
//   - uart_state_t : receiver FSM state encoding (3 bits)
//   - calc_cpb     : clocks per bit, CLK_FREQ/BAUD truncated
//   - calc_half    : half a bit period, CPB/2 truncated
//   - cnt_width    : width of a counter that must hold values 0..n-1
//   - even_parity_err : 1 when data plus parity bit hold an odd number of ones
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        LINE_WAIT = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        PARITY    = 3'd4,
        STOP      = 3'd5
    } uart_state_t;

    function automatic int calc_cpb(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int calc_half(input int cpb);
        return cpb / 2;
    endfunction

    // Never returns 0 so a degenerate count still yields a legal vector.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Narrower data words are zero-extended by the caller; zeros do not
    // change the parity.
    function automatic logic even_parity_err(input logic [7:0] data, input logic par_bit);
        return (^data) ^ par_bit;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// -----------------------------------------------------------------------------
// uart_baud_cnt
// Free-running up-counter with a programmable terminal count. tick_o is high
// for the clock on which the count equals limit_i; the counter restarts from
// zero on that clock and whenever clr_i is high.
// Ports:
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset
//   clr_i   : synchronous clear (parent asserts on every state entry)
//   limit_i : terminal count
//   tick_o  : count == limit_i this clock
// -----------------------------------------------------------------------------
module uart_baud_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic             tick_o
);

    localparam logic [WIDTH-1:0] CNT_ZERO = WIDTH'(0);
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] cnt_r;

    assign tick_o = (cnt_r == limit_i);

    // Count register: restart on clear or on reaching the terminal count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r <= CNT_ZERO;
        end else if (clr_i || tick_o) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

endmodule

// File: rtl/uart_rx_deser.sv
// -----------------------------------------------------------------------------
// uart_rx_deser
// Asynchronous-serial receiver with mid-bit sampling. Frame is start +
// DATA_BITS (LSB first) [+ even parity] + stop. CLK_FREQ/BAUD must be >= 4.
// Optional feature macro: UART_RX_PARITY_EN (adds the even-parity bit).
// Ports:
//   clk_i        : system clock
//   rst_i        : asynchronous active-high reset
//   rxd_i        : serial line, already synchronised to clk_i, idle high
//   data_o       : last correctly framed word, held between frames
//   valid_o      : one-cycle pulse, data_o updated this cycle
//   frame_err_o  : one-cycle pulse, stop bit sampled low
//   parity_err_o : one-cycle pulse with valid_o on parity mismatch (0 without macro)
//   busy_o       : high in every state except IDLE
// -----------------------------------------------------------------------------
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rxd_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 busy_o
);

    localparam int CPB  = calc_cpb(CLK_FREQ, BAUD);
    localparam int HALF = calc_half(CPB);
    localparam int CW   = cnt_width(CPB);
    localparam int BW   = cnt_width(DATA_BITS);

    localparam logic [CW-1:0]        HALF_LIM = CW'(HALF - 1);
    localparam logic [CW-1:0]        FULL_LIM = CW'(CPB - 1);
    localparam logic [BW-1:0]        LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0]        BIT_ONE  = BW'(1);
    localparam logic [DATA_BITS-1:0] DATA_ZERO = {DATA_BITS{1'b0}};

    uart_state_t          state_r, state_next_s;
    logic [CW-1:0]        limit_s;
    logic                 cnt_clr_s;
    logic                 tick_s;
    logic [DATA_BITS-1:0] shift_r, shift_next_s;
    logic [BW-1:0]        bit_idx_r, bit_idx_next_s;
    logic [DATA_BITS-1:0] data_r, data_next_s;
    logic                 valid_r, valid_next_s;
    logic                 frame_err_r, frame_err_next_s;
    logic                 busy_r;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_r, par_bad_next_s;
    logic                 par_pulse_r, par_pulse_next_s;
`endif

    // Every state entry restarts the bit timer.
    assign cnt_clr_s = (state_next_s != state_r);

    // Terminal count: half a bit to reach the middle of the start bit,
    // a full bit everywhere else.
    always_comb begin
        if (state_r == START) begin
            limit_s = HALF_LIM;
        end else begin
            limit_s = FULL_LIM;
        end
    end

    uart_baud_cnt #(
        .WIDTH (CW)
    ) u_baud_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (cnt_clr_s),
        .limit_i (limit_s),
        .tick_o  (tick_s)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_next_s     = state_r;
        shift_next_s     = shift_r;
        bit_idx_next_s   = bit_idx_r;
        data_next_s      = data_r;
        valid_next_s     = 1'b0;
        frame_err_next_s = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_next_s   = par_bad_r;
        par_pulse_next_s = 1'b0;
`endif
        case (state_r)
            // Wait for an idle (high) line so a line held low is never decoded.
            LINE_WAIT: begin
                if (rxd_i) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = LINE_WAIT;
                end
            end
            IDLE: begin
                if (!rxd_i) begin
                    state_next_s = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            // A start bit that is high again at its middle was a glitch.
            START: begin
                if (tick_s) begin
                    if (rxd_i) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s   = DATA;
                        bit_idx_next_s = {BW{1'b0}};
                    end
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (tick_s) begin
                    shift_next_s = {rxd_i, shift_r[DATA_BITS-1:1]};
                    if (bit_idx_r == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_next_s = PARITY;
`else
                        state_next_s = STOP;
`endif
                    end else begin
                        bit_idx_next_s = bit_idx_r + BIT_ONE;
                    end
                end else begin
                    state_next_s = DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick_s) begin
                    par_bad_next_s = even_parity_err(8'(shift_r), rxd_i);
                    state_next_s   = STOP;
                end else begin
                    state_next_s = PARITY;
                end
            end
`endif
            // Sampled mid-stop-bit, so IDLE is back before the next start bit.
            STOP: begin
                if (tick_s) begin
                    if (rxd_i) begin
                        data_next_s  = shift_r;
                        valid_next_s = 1'b1;
`ifdef UART_RX_PARITY_EN
                        par_pulse_next_s = par_bad_r;
`endif
                        state_next_s = IDLE;
                    end else begin
                        frame_err_next_s = 1'b1;
                        state_next_s     = LINE_WAIT;
                    end
                end else begin
                    state_next_s = STOP;
                end
            end
            default: begin
                state_next_s = LINE_WAIT;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= LINE_WAIT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_r     <= DATA_ZERO;
            bit_idx_r   <= {BW{1'b0}};
            data_r      <= DATA_ZERO;
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_r   <= 1'b0;
            par_pulse_r <= 1'b0;
`endif
        end else begin
            shift_r     <= shift_next_s;
            bit_idx_r   <= bit_idx_next_s;
            data_r      <= data_next_s;
            valid_r     <= valid_next_s;
            frame_err_r <= frame_err_next_s;
            busy_r      <= (state_next_s != IDLE);
`ifdef UART_RX_PARITY_EN
            par_bad_r   <= par_bad_next_s;
            par_pulse_r <= par_pulse_next_s;
`endif
        end
    end

    assign data_o      = data_r;
    assign valid_o     = valid_r;
    assign frame_err_o = frame_err_r;
    assign busy_o      = busy_r;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = par_pulse_r;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deser.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_deser
// Self-checking bench for uart_rx_deser at CLK_FREQ=1 MHz, BAUD=100 kHz
// (10 clocks per bit). Frames are described at byte level; the expected
// pulse list (cycle, data, kind) is derived from the frame contents and the
// start cycle, then compared against every pulse the DUT produced.
// Honours UART_RX_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_uart_rx_deser;

    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 100000;
    localparam int DBITS    = 8;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int HALF     = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN   = 1'b1;
    localparam int LAT      = HALF + (DBITS + 2) * CPB;
    localparam int FRAME    = (DBITS + 3) * CPB;
`else
    localparam bit PAR_EN   = 1'b0;
    localparam int LAT      = HALF + (DBITS + 1) * CPB;
    localparam int FRAME    = (DBITS + 2) * CPB;
`endif

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  data;
        logic        v;
        logic        fe;
        logic        pe;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] data_o;
    logic       valid_o, frame_err_o, parity_err_o, busy_o;

    logic [31:0] cyc = 32'd0;
    int          both_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  last_good = 8'h00;
    ev_t         got_q[$];
    ev_t         exp_q[$];

    uart_rx_deser #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .DATA_BITS (DBITS)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rxd_i        (rxd),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    // Record every output pulse, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst && (valid_o || frame_err_o || parity_err_o)) begin
            got_q.push_back({cyc, data_o, valid_o, frame_err_o, parity_err_o});
        end
        if (valid_o && frame_err_o) begin
            both_cnt <= both_cnt + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one frame and append the expected outcome. The line is left at
    // the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        ev_t e;
        logic [31:0] s;
        s = cyc + 32'd1;
        drive_bit(1'b0);
        for (int i = 0; i < DBITS; i++) drive_bit(d[i]);
        if (PAR_EN) drive_bit(par_b);
        drive_bit(stop_b);
        e.cyc = s + 32'(LAT);
        if (stop_b) begin
            e.data = d;
            e.v    = 1'b1;
            e.fe   = 1'b0;
            e.pe   = PAR_EN & ((^d) ^ par_b);
            last_good = d;
        end else begin
            e.data = last_good;
            e.v    = 1'b0;
            e.fe   = 1'b1;
            e.pe   = 1'b0;
        end
        exp_q.push_back(e);
    endtask

    task automatic clear_q;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_o); end
        checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", frame_err_o); end
        checks++; if (parity_err_o !== 1'b0) begin errors++; $display("FAIL reset_perr got %b exp 0", parity_err_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
        rst = 1'b0;
        last_good = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b exp 0", busy_o); end
    endtask

    task automatic test_basic;
        clear_q();
        idle(3);
        send_frame(8'hA5, 1'b1, ^8'hA5);
        idle(5);
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL basic_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_ev%0d got %p exp %p", i, got_q[i], exp_q[i]); end
            end
        end
        checks++; if (data_o !== 8'hA5) begin errors++; $display("FAIL basic_data got %h exp a5", data_o); end
    endtask

    task automatic test_glitch;
        clear_q();
        rxd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL glitch_busy_start got %b exp 1", busy_o); end
        @(posedge clk);
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL glitch_busy_sample got %b exp 0", busy_o); end
        idle(120);
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL glitch_pulses got %0d exp 0", got_q.size()); end
    endtask

    task automatic test_frame_err;
        clear_q();
        send_frame(8'h3C, 1'b0, ^8'h3C);
        rxd = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL break_busy got %b exp 1", busy_o); end
        checks++; if (data_o !== 8'hA5) begin errors++; $display("FAIL break_data got %h exp a5", data_o); end
        idle(5);
        send_frame(8'h5A, 1'b1, ^8'h5A);
        idle(5);
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL ferr_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ferr_ev%0d got %p exp %p", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_back_to_back;
        clear_q();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle(5);
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_ev%0d got %p exp %p", i, got_q[i], exp_q[i]); end
            end
        end
        if (got_q.size() == 2) begin
            checks++;
            if (got_q[1].cyc - got_q[0].cyc !== 32'(FRAME)) begin
                errors++; $display("FAIL b2b_spacing got %0d exp %0d", got_q[1].cyc - got_q[0].cyc, FRAME);
            end
        end
    endtask

    task automatic test_reset_mid;
        clear_q();
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        rxd = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h exp 00", data_o); end
        rst = 1'b0;
        last_good = 8'h00;
        repeat (50) @(posedge clk);
        #1;
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rstmid_linewait got %b exp 1", busy_o); end
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL rstmid_pulses got %0d exp 0", got_q.size()); end
        idle(3);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_idle got %b exp 0", busy_o); end
        send_frame(8'h81, 1'b1, ^8'h81);
        idle(5);
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rstmid_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_ev%0d got %p exp %p", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        clear_q();
        send_frame(8'h07, 1'b1, 1'b0);
        idle(3);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(5);
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL parity_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL parity_ev%0d got %p exp %p", i, got_q[i], exp_q[i]); end
            end
        end
    endtask
`endif

    task automatic test_random;
        logic [7:0] d;
        logic       bad;
        logic       pb;
        clear_q();
        for (int n = 0; n < 24; n++) begin
            d   = 8'($urandom);
            bad = ($urandom_range(0, 7) == 0);
            pb  = 1'($urandom);
            send_frame(d, !bad, pb);
            if (bad) idle($urandom_range(2, 6));
            else     idle($urandom_range(0, 4));
        end
        idle(5);
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL random_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_ev%0d got %p exp %p", i, got_q[i], exp_q[i]); end
            end
        end
        checks++; if (data_o !== last_good) begin errors++; $display("FAIL random_hold got %h exp %h", data_o, last_good); end
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL valid_ferr_overlap got %0d exp 0", both_cnt); end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
